snn_pool_window_scheduler: RTL

- Sequences the SNN max-pooling layer.
- Round-robin merges NUM_SOURCES upstream spike streams (conv output channels or groups) into the pool layer's single 48-bit AXI-Stream input.
- Times the pooling window, drains in-flight spikes at window end, and triggers and awaits the pool layer's output scan before opening the next window.

---
 rtl/snn_pool_window_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/snn_pool_window_scheduler.sv
// Window scheduler for the SNN max-pool layer: round-robin spike merge,
// window timing, drain, and pool output-scan handshake.
module snn_pool_window_scheduler #(
  parameter int NUM_SOURCES  = 4,
  parameter int TIME_WIDTH   = 16,
  parameter int SCAN_TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [48*NUM_SOURCES-1:0] s_axis_tdata,
  input  logic [NUM_SOURCES-1:0]    s_axis_tvalid,
  output logic [NUM_SOURCES-1:0]    s_axis_tready,
  input  logic [NUM_SOURCES-1:0]    s_axis_tlast,
  output logic [47:0]               m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  input  logic [TIME_WIDTH-1:0]     window_cycles,
  output logic                      pool_scan_start,
  input  logic                      pool_scan_done,
  output logic [1:0]                sched_state,
  output logic [31:0]               window_count,
  output logic [31:0]               forwarded_count,
  output logic [31:0]               dropped_count,
  output logic                      timeout_error
);

  localparam int RRW = $clog2(NUM_SOURCES);
  localparam int STW = $clog2(SCAN_TIMEOUT) + 1;

  localparam logic [RRW:0] NSRC =
    (RRW+1)'(NUM_SOURCES);
  localparam logic [STW-1:0] SCAN_LAST =
    STW'(SCAN_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_SCAN    = 2'd3;

  logic [1:0]            r_state;
  logic [TIME_WIDTH-1:0] r_timer;
  logic [STW-1:0]        r_scan_timer;
  logic [RRW-1:0]        r_rr;
  logic [47:0]           r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic                  r_scan_start;
  logic [31:0]           r_win_cnt;
  logic [31:0]           r_fwd_cnt;
  logic [31:0]           r_drop_cnt;
  logic                  r_timeout;

  logic                  w_out_ready;
  logic                  w_any;
  logic [RRW-1:0]        w_grant;
  logic [RRW-1:0]        w_rr_next;
  logic                  w_hs;
  logic                  w_keep;
  logic [47:0]           w_sel_data;
  logic                  w_sel_last;
  logic [NUM_SOURCES-1:0] w_tready;
  logic [TIME_WIDTH-1:0] w_limit;
  logic                  w_win_end;
  logic                  w_done_ok;
  logic                  w_scan_hit;
  logic                  w_scan_fin;
  logic                  w_scan_to;
  logic [1:0]            w_after_scan;

  assign w_out_ready = !r_m_tvalid || m_axis_tready;

  // Circular priority search starting at the rr pointer
  always_comb begin
    logic [RRW:0] w_sum;
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      w_sum = {1'b0, r_rr} + (RRW+1)'(k);
      if (w_sum >= NSRC) w_sum = w_sum - NSRC;
      if (!w_any && s_axis_tvalid[w_sum[RRW-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_sum[RRW-1:0];
      end
    end
  end

  always_comb begin
    logic [RRW:0] w_nxt;
    w_nxt = {1'b0, w_grant} + (RRW+1)'(1);
    if (w_nxt >= NSRC) w_nxt = '0;
    w_rr_next = w_nxt[RRW-1:0];
  end

  assign w_hs = (r_state == ST_COLLECT) &&
                w_out_ready && w_any;

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    w_tready   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_grant == RRW'(i)) begin
        w_sel_data  = s_axis_tdata[i*48 +: 48];
        w_sel_last  = s_axis_tlast[i];
        w_tready[i] = w_hs;
      end
    end
  end

  assign w_keep = (w_sel_data[7:0] != 8'h00);

  assign w_limit = (window_cycles == '0) ? '0 :
                   window_cycles - TIME_WIDTH'(1);

  // >= so a shrinking window ends at once instead of wrapping
  assign w_win_end = !enable || (r_timer >= w_limit);

  // done is ignored while the start pulse itself is high
  assign w_done_ok  = !r_scan_start && pool_scan_done;
  assign w_scan_hit = (r_scan_timer == SCAN_LAST);
  assign w_scan_fin = w_done_ok || w_scan_hit;
  assign w_scan_to  = w_scan_hit && !w_done_ok;

  assign w_after_scan = enable ? ST_COLLECT : ST_IDLE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_rr       <= '0;
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_hs) r_rr <= w_rr_next;
      if (w_hs && w_keep) begin
        r_m_tdata  <= w_sel_data;
        r_m_tlast  <= w_sel_last;
        r_m_tvalid <= 1'b1;
        r_fwd_cnt  <= r_fwd_cnt + 32'd1;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_hs && !w_keep)
        r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_scan_timer <= '0;
      r_scan_start <= 1'b0;
      r_win_cnt    <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_scan_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_COLLECT;
            r_timer <= '0;
          end
        end
        ST_COLLECT: begin
          r_timer <= r_timer + TIME_WIDTH'(1);
          if (w_win_end) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_out_ready) begin
            r_scan_start <= 1'b1;
            r_scan_timer <= '0;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_scan_fin) begin
            r_win_cnt <= r_win_cnt + 32'd1;
            r_state   <= w_after_scan;
            r_timer   <= '0;
            if (w_scan_to) r_timeout <= 1'b1;
          end else begin
            r_scan_timer <= r_scan_timer + STW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready   = w_tready;
  assign m_axis_tdata    = r_m_tdata;
  assign m_axis_tvalid   = r_m_tvalid;
  assign m_axis_tlast    = r_m_tlast;
  assign pool_scan_start = r_scan_start;
  assign sched_state     = r_state;
  assign window_count    = r_win_cnt;
  assign forwarded_count = r_fwd_cnt;
  assign dropped_count   = r_drop_cnt;
  assign timeout_error   = r_timeout;

endmodule
